// File: rtl/rx_eyeq_responder.sv
// ---------------------------------------------------------------------------
// rx_eyeq_responder
//   PHY-side responder for the RX eye-quality (EyeQ) 4-way handshake.
//   Accepts a level request plus mode from the MAC-side controller, counts
//   good slicer samples over a mode-dependent window, then raises done and
//   holds the result until the request is withdrawn.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   rxeyeqreq_i  EyeQ request (level)
//   rxeyeqmode_i eyeqmode_t, sampled only on the accept cycle
//   rxpdwn_i     powerdown_t (00 NORMAL, 01 IDLE, 11 SLEEP, 10 COMA)
//   smp_valid_i  slicer sample present this cycle
//   smp_err_i    present sample is in error (ignored when !smp_valid_i)
//   rxeyeqdone_o EyeQ done (level)
//   rxeyeq_o     measured eye quality (count of good samples, saturating)
//   eyeq_status_o 00 ok, 01 illegal mode, 10 aborted by powerdown
//   proto_err_o  one-cycle pulse when the request is withdrawn mid-measure
// ---------------------------------------------------------------------------
module rx_eyeq_responder #(
  parameter int EYEQ_W      = 16,
  parameter int WIN_STARTUP = 64,
  parameter int WIN_BG      = 32,
  parameter int WIN_WAKE    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxeyeqreq_i,
  input  logic [3:0]        rxeyeqmode_i,
  input  logic [1:0]        rxpdwn_i,
  input  logic              smp_valid_i,
  input  logic              smp_err_i,
  output logic              rxeyeqdone_o,
  output logic [EYEQ_W-1:0] rxeyeq_o,
  output logic [1:0]        eyeq_status_o,
  output logic              proto_err_o
);

  localparam int WIN_MAX0 = (WIN_STARTUP > WIN_BG) ? WIN_STARTUP : WIN_BG;
  localparam int WIN_MAX  = (WIN_MAX0 > WIN_WAKE) ? WIN_MAX0 : WIN_WAKE;
  localparam int CNT_W    = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

  localparam logic [1:0] PD_NORMAL  = 2'b00;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [EYEQ_W-1:0]  acc_q, acc_d;
  logic [EYEQ_W-1:0]  eyeq_q, eyeq_d;
  logic [1:0]         status_q, status_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;

  // Mode decode. The latched mode only matters for the window length, so
  // it is captured as the win_cnt load value rather than kept separately.
  // Any unlisted encoding (including X/Z in simulation) falls to illegal.
  logic               mode_legal;
  logic [CNT_W-1:0]   mode_win;

  always_comb begin
    mode_legal = 1'b0;
    mode_win   = '0;
    case (rxeyeqmode_i)
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
        mode_legal = 1'b1;
        mode_win   = CNT_W'(WIN_STARTUP - 1);
      end
      4'b1010, 4'b1011, 4'b1100: begin
        mode_legal = 1'b1;
        mode_win   = CNT_W'(WIN_BG - 1);
      end
      4'b1101: begin
        mode_legal = 1'b1;
        mode_win   = CNT_W'(WIN_WAKE - 1);
      end
      default: ;
    endcase
  end

  // Accumulator value including this cycle's sample, saturating at all-ones.
  logic              smp_good;
  logic [EYEQ_W-1:0] acc_nxt;

  assign smp_good = smp_valid_i & ~smp_err_i;
  assign acc_nxt  = (smp_good && !(&acc_q)) ? acc_q + EYEQ_W'(1) : acc_q;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    acc_d    = acc_q;
    eyeq_d   = eyeq_q;
    status_d = status_q;
    done_d   = done_q;
    perr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rxeyeqreq_i && !done_q) begin
          if (rxpdwn_i != PD_NORMAL) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
            eyeq_d   = '0;
            done_d   = 1'b1;
          end else if (!mode_legal) begin
            state_d  = S_DONE;
            status_d = ST_ILLEGAL;
            eyeq_d   = '0;
            done_d   = 1'b1;
          end else begin
            state_d = S_MEASURE;
            win_d   = mode_win;
            acc_d   = '0;
          end
        end
      end
      S_MEASURE: begin
        // Priority: withdrawal > powerdown abort > window completion.
        if (!rxeyeqreq_i) begin
          perr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (rxpdwn_i != PD_NORMAL) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
          eyeq_d   = '0;
          done_d   = 1'b1;
        end else begin
          acc_d = acc_nxt;
          if (win_q == '0) begin
            state_d  = S_DONE;
            eyeq_d   = acc_nxt;
            status_d = ST_OK;
            done_d   = 1'b1;
          end else begin
            win_d = win_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // Result and status hold here; rxeyeq also persists through IDLE.
        if (!rxeyeqreq_i) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      acc_q    <= '0;
      eyeq_q   <= '0;
      status_q <= 2'b00;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      eyeq_q   <= eyeq_d;
      status_q <= status_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
    end
  end

  assign rxeyeqdone_o  = done_q;
  assign rxeyeq_o      = eyeq_q;
  assign eyeq_status_o = status_q;
  assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_rx_eyeq_responder.sv
module tb_rx_eyeq_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  mode;
  logic [1:0]  pdwn;
  logic        sv, se;
  logic        done;
  logic [15:0] eyeq;
  logic [1:0]  status;
  logic        perr;

  rx_eyeq_responder #(
    .EYEQ_W(16), .WIN_STARTUP(64), .WIN_BG(32), .WIN_WAKE(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rxeyeqreq_i  (req),
    .rxeyeqmode_i (mode),
    .rxpdwn_i     (pdwn),
    .smp_valid_i  (sv),
    .smp_err_i    (se),
    .rxeyeqdone_o (done),
    .rxeyeq_o     (eyeq),
    .eyeq_status_o(status),
    .proto_err_o  (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          proto;
    logic [15:0] e;
    logic [1:0]  s;
    int          at;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a request; lat<0 means the expected response is pushed later by
  // the caller (abort / withdrawal cases).
  task automatic issue(input logic [3:0] m, input int lat,
                       input logic [15:0] e, input logic [1:0] s);
    exp_t x;
    mode = m;
    req  = 1'b1;
    if (lat >= 0) begin
      x.proto = 1'b0; x.e = e; x.s = s; x.at = cyc + 1 + lat;
      q.push_back(x);
    end
    step(1);
    mode = 4'b1111;  // post-accept mode changes must be ignored
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic release_req();
    req = 1'b0;
    step(1);
    chk("release_done_fall", {31'd0, done}, 32'd0);
  endtask

  // Monitor: pops expectations when done rises or proto_err pulses, and
  // checks the result stays stable while done is high.
  logic        done_prev = 1'b0;
  logic [15:0] held_e;
  logic [1:0]  held_s;

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            x = q.pop_front();
            chk("mon_kind_done", {31'd0, x.proto}, 32'd0);
            chk("mon_eyeq", {16'd0, eyeq}, {16'd0, x.e});
            chk("mon_status", {30'd0, status}, {30'd0, x.s});
            chk("mon_latency", cyc, x.at);
          end
          held_e = eyeq;
          held_s = status;
        end else if (done === 1'b1) begin
          chk("hold_eyeq", {16'd0, eyeq}, {16'd0, held_e});
          chk("hold_status", {30'd0, status}, {30'd0, held_s});
        end
        if (perr === 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_proto_err", {31'd0, perr}, 32'd0);
          end else begin
            x = q.pop_front();
            chk("mon_kind_proto", {31'd0, x.proto}, 32'd1);
            chk("mon_proto_time", cyc, x.at);
          end
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    rst = 1'b1; req = 1'b0; mode = 4'b0000; pdwn = 2'b00; sv = 1'b1; se = 1'b0;
    step(3);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_eyeq", {16'd0, eyeq}, 32'd0);
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_perr", {31'd0, perr}, 32'd0);
    rst = 1'b0;
    step(2);

    // Nominal STARTUP window, all samples good.
    issue(4'b0100, 64, 16'd64, 2'b00);
    wait_done(200);
    step(2);
    chk("nom_hold", {16'd0, eyeq}, 32'd64);
    release_req();
    chk("nom_keep_idle", {16'd0, eyeq}, 32'd64);
    step(2);

    // BACKGROUND window with 5 errored and 3 missing samples -> 24.
    issue(4'b1010, 32, 16'd24, 2'b00);
    for (int i = 0; i < 32; i++) begin
      sv = !(i == 7 || i == 11 || i == 30);
      se = (i == 2 || i == 5 || i == 9 || i == 14 || i == 20);
      step(1);
    end
    sv = 1'b1; se = 1'b0;
    wait_done(10);
    release_req();
    step(2);

    // Illegal mode: done on the accept edge, status 01.
    issue(4'b0111, 0, 16'd0, 2'b01);
    wait_done(5);
    release_req();
    step(2);

    // Powerdown abort at MEASURE cycle 10.
    issue(4'b0001, -1, 16'd0, 2'b00);
    step(9);
    pdwn = 2'b01;
    x.proto = 1'b0; x.e = 16'd0; x.s = 2'b10; x.at = cyc + 1;
    q.push_back(x);
    wait_done(5);
    release_req();
    pdwn = 2'b00;
    step(2);

    // Request withdrawn at MEASURE cycle 20.
    issue(4'b0001, -1, 16'd0, 2'b00);
    step(19);
    req = 1'b0;
    x.proto = 1'b1; x.e = 16'd0; x.s = 2'b00; x.at = cyc + 1;
    q.push_back(x);
    step(1);
    chk("perr_pulse", {31'd0, perr}, 32'd1);
    step(1);
    chk("perr_one_cycle", {31'd0, perr}, 32'd0);
    chk("perr_no_done", {31'd0, done}, 32'd0);
    step(70);
    chk("perr_still_no_done", {31'd0, done}, 32'd0);

    // Reset while in DONE clears every output.
    issue(4'b1101, 16, 16'd16, 2'b00);
    wait_done(40);
    rst = 1'b1; req = 1'b0;
    step(1);
    chk("rst_done_done", {31'd0, done}, 32'd0);
    chk("rst_done_eyeq", {16'd0, eyeq}, 32'd0);
    chk("rst_done_status", {30'd0, status}, 32'd0);
    chk("rst_done_perr", {31'd0, perr}, 32'd0);
    rst = 1'b0;
    step(2);

    // Back-to-back with a one-cycle req-low gap.
    issue(4'b1101, 16, 16'd16, 2'b00);
    wait_done(40);
    req = 1'b0;
    step(1);
    chk("b2b_gap_done", {31'd0, done}, 32'd0);
    issue(4'b1011, 32, 16'd32, 2'b00);
    chk("b2b_low_after_accept", {31'd0, done}, 32'd0);
    wait_done(60);
    release_req();
    step(3);

    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
